// File: rtl/mips_chk_pkg.sv
// ============================================================================
// Module      : mips_chk_pkg
// Description : Shared types and constants for the MIPS result checker.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mips_chk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_SETTLE = 3'd2,
        ST_PASS   = 3'd3,
        ST_TOUT   = 3'd4
    } chk_state_e;

    localparam int unsigned ZERO_REG = 0;
    localparam int          DEF_DW   = 32;
    localparam int          DEF_RAW  = 5;

endpackage

`default_nettype wire

// File: rtl/mips_chk_channel.sv
// ============================================================================
// Module      : mips_chk_channel
// Description : One watched-register channel: latched config, shadow, match.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mips_chk_channel
    import mips_chk_pkg::*;
#(
    parameter int DW  = DEF_DW,
    parameter int RAW = DEF_RAW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear_i,
    input  logic           snoop_i,
    input  logic           cfg_en_i,
    input  logic [RAW-1:0] cfg_addr_i,
    input  logic [DW-1:0]  cfg_val_i,
    input  logic           wb_en_i,
    input  logic [RAW-1:0] wb_addr_i,
    input  logic [DW-1:0]  wb_data_i,
    output logic           match_o
);

    logic           en_q;
    logic [RAW-1:0] addr_q;
    logic [DW-1:0]  val_q;
    logic [DW-1:0]  shadow_q, shadow_d;
    logic           valid_q, valid_d;
    logic           match_q, match_d;
    logic           w_is_zero;
    logic           w_hit;

    assign w_is_zero = (addr_q == RAW'(ZERO_REG));
    assign w_hit     = snoop_i && wb_en_i && (wb_addr_i == addr_q) && !w_is_zero;

    // Match is computed from the post-write shadow so it lands one cycle after the write.
    always_comb begin
        shadow_d = w_hit ? wb_data_i : shadow_q;
        valid_d  = valid_q | w_hit;
        if (!en_q)
            match_d = 1'b1;
        else if (w_is_zero)
            match_d = (val_q == '0);
        else
            match_d = valid_d && (shadow_d == val_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q     <= 1'b0;
            addr_q   <= '0;
            val_q    <= '0;
            shadow_q <= '0;
            valid_q  <= 1'b0;
            match_q  <= 1'b0;
        end else if (clear_i) begin
            en_q     <= cfg_en_i;
            addr_q   <= cfg_addr_i;
            val_q    <= cfg_val_i;
            shadow_q <= '0;
            valid_q  <= 1'b0;
            match_q  <= 1'b0;
        end else if (snoop_i) begin
            shadow_q <= shadow_d;
            valid_q  <= valid_d;
            match_q  <= match_d;
        end
    end

    assign match_o = match_q;

endmodule

`default_nettype wire

// File: rtl/mips_result_checker.sv
// ============================================================================
// Module      : mips_result_checker
// Description : Pass/fail checker snooping GPR write-back of the MIPS core.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mips_result_checker
    import mips_chk_pkg::*;
#(
    parameter int NUM_CHK = 4,
    parameter int DW      = DEF_DW,
    parameter int RAW     = DEF_RAW,
    parameter int SETTLE  = 5,
    parameter int TIMEOUT = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [NUM_CHK-1:0]     chk_en,
    input  logic [NUM_CHK*RAW-1:0] chk_addr,
    input  logic [NUM_CHK*DW-1:0]  chk_val,
    input  logic                   wb_en,
    input  logic [RAW-1:0]         wb_addr,
    input  logic [DW-1:0]          wb_data,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [NUM_CHK-1:0]     match_vec,
    output logic [31:0]            cycle_cnt
);

    localparam int SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

    chk_state_e   state_q, state_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [31:0]   cnt_q, cnt_d;
    logic          busy_q, done_q, pass_q;
    logic          w_running;
    logic          w_start_acc;
    logic          w_all_match;
    logic [NUM_CHK-1:0] w_match;

    assign w_running   = (state_q == ST_RUN) || (state_q == ST_SETTLE);
    assign w_start_acc = start && !w_running;
    assign w_all_match = &w_match;

    for (genvar i = 0; i < NUM_CHK; i++) begin : g_chan
        mips_chk_channel #(
            .DW  (DW),
            .RAW (RAW)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .clear_i    (w_start_acc),
            .snoop_i    (w_running),
            .cfg_en_i   (chk_en[i]),
            .cfg_addr_i (chk_addr[i*RAW +: RAW]),
            .cfg_val_i  (chk_val[i*DW +: DW]),
            .wb_en_i    (wb_en),
            .wb_addr_i  (wb_addr),
            .wb_data_i  (wb_data),
            .match_o    (w_match[i])
        );
    end

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        cnt_d   = cnt_q;
        if (w_start_acc) begin
            state_d = ST_RUN;
            scnt_d  = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    cnt_d = cnt_q + 32'd1;
                    if (w_all_match) begin
                        state_d = ST_SETTLE;
                        scnt_d  = SW'(1);
                    end
                end
                ST_SETTLE: begin
                    cnt_d = cnt_q + 32'd1;
                    if (!w_all_match) begin
                        state_d = ST_RUN;
                        scnt_d  = '0;
                    end else if (scnt_q == SW'(SETTLE)) begin
                        state_d = ST_PASS;
                    end else begin
                        scnt_d = scnt_q + SW'(1);
                    end
                end
                default: ;
            endcase
            // A pass on the final allowed edge takes precedence over timeout.
            if (w_running && (state_d != ST_PASS) && (cnt_q == 32'(TIMEOUT - 1)))
                state_d = ST_TOUT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            scnt_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == ST_RUN) || (state_d == ST_SETTLE);
            done_q  <= (state_d == ST_PASS) || (state_d == ST_TOUT);
            pass_q  <= (state_d == ST_PASS);
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign match_vec = w_match;
    assign cycle_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_result_checker.sv
// ============================================================================
// Module      : tb_mips_result_checker
// Description : Directed self-checking bench for mips_result_checker.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mips_result_checker;

    localparam int NUM_CHK = 4;
    localparam int DW      = 32;
    localparam int RAW     = 5;
    localparam int SETTLE  = 5;
    localparam int TIMEOUT = 64;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic [NUM_CHK-1:0]     chk_en;
    logic [NUM_CHK*RAW-1:0] chk_addr;
    logic [NUM_CHK*DW-1:0]  chk_val;
    logic                   wb_en;
    logic [RAW-1:0]         wb_addr;
    logic [DW-1:0]          wb_data;
    logic                   busy, done, pass;
    logic [NUM_CHK-1:0]     match_vec;
    logic [31:0]            cycle_cnt;

    typedef struct {
        int          cyc;
        logic        pass;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cur   = 0;

    mips_result_checker #(
        .NUM_CHK (NUM_CHK),
        .DW      (DW),
        .RAW     (RAW),
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .chk_en    (chk_en),
        .chk_addr  (chk_addr),
        .chk_val   (chk_val),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .match_vec (match_vec),
        .cycle_cnt (cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cur++;
    endtask

    task automatic goto_cycle(input int n);
        while (cur < n) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_pass"}, {31'd0, pass}, 32'd0);
        check({tag, "_mvec"}, {28'd0, match_vec}, 32'd0);
        check({tag, "_cnt"}, cycle_cnt, 32'd0);
    endtask

    task automatic write(input int c, input logic [4:0] a, input logic [31:0] d);
        goto_cycle(c);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        tick();
        wb_en = 1'b0;
    endtask

    // Pulse start; afterwards the bench sits in cycle 1 of the run.
    task automatic do_start(input logic [3:0] en, input logic [19:0] ad, input logic [127:0] vl);
        chk_en = en; chk_addr = ad; chk_val = vl;
        start = 1'b1;
        tick();
        start = 1'b0;
        cur = 1;
    endtask

    task automatic wait_done(input string tag, input int limit);
        exp_t e;
        int   n;
        n = 0;
        while (!done && n < limit) begin
            tick();
            n++;
        end
        e = sb.pop_front();
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_cyc"}, 32'(cur), 32'(e.cyc));
        check({tag, "_pass"}, {31'd0, pass}, {31'd0, e.pass});
        check({tag, "_cnt"}, cycle_cnt, e.cnt);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [19:0]  basic_a;
        logic [127:0] basic_v;
        exp_t         e;
        basic_a = {5'd0, 5'd0, 5'd0, 5'd16};
        basic_v = {96'd0, 32'h0000_1234};

        rst = 1'b0; start = 1'b0; chk_en = '0; chk_addr = '0; chk_val = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        tick(); tick();
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        // Basic pass
        do_start(4'b0001, basic_a, basic_v);
        check("b_busy1", {31'd0, busy}, 32'd1);
        check("b_mvec1", {28'd0, match_vec}, 32'h0);
        e.cyc = 17; e.pass = 1'b1; e.cnt = 32'd16; sb.push_back(e);
        write(10, 5'd16, 32'h0000_1234);
        check("b_mvec11", {28'd0, match_vec}, 32'hF);
        wait_done("basic", 40);

        // Disturbance, with a write coinciding with start that must be dropped
        chk_en = 4'b0001; chk_addr = basic_a; chk_val = basic_v;
        wb_en = 1'b1; wb_addr = 5'd16; wb_data = 32'h0000_1234;
        start = 1'b1;
        tick();
        start = 1'b0; wb_en = 1'b0; cur = 1;
        check("d_mvec1", {28'd0, match_vec}, 32'h0);
        tick();
        check("d_mvec2", {28'd0, match_vec}, 32'hE);
        e.cyc = 22; e.pass = 1'b1; e.cnt = 32'd21; sb.push_back(e);
        write(10, 5'd16, 32'h0000_1234);
        write(13, 5'd16, 32'h0000_0000);
        check("d_mvec14", {31'd0, match_vec[0]}, 32'd0);
        write(15, 5'd16, 32'h0000_1234);
        wait_done("disturb", 40);

        // Timeout
        do_start(4'b0001, basic_a, basic_v);
        e.cyc = 65; e.pass = 1'b0; e.cnt = 32'd64; sb.push_back(e);
        wait_done("tout", 100);

        // Mixed channels
        do_start(4'b1011, {5'd8, 5'd8, 5'd8, 5'd0},
                 {32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h0});
        e.cyc = 10; e.pass = 1'b1; e.cnt = 32'd9; sb.push_back(e);
        goto_cycle(3);
        check("m_mvec3", {28'd0, match_vec}, 32'h5);
        write(3, 5'd8, 32'hFFFF_FFFF);
        check("m_mvec4", {28'd0, match_vec}, 32'hF);
        wait_done("mixed", 40);

        // Start while busy is ignored; reset mid-run clears everything
        do_start(4'b0001, basic_a, basic_v);
        goto_cycle(3);
        do_start(4'b0001, basic_a, {96'd0, 32'h0000_5555});
        cur = 4;
        write(5, 5'd16, 32'h0000_1234);
        check("r_mvec6", {28'd0, match_vec}, 32'hF);
        check("r_cnt6", cycle_cnt, 32'd5);
        check("r_busy6", {31'd0, busy}, 32'd1);
        goto_cycle(8);
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        tick(); tick();
        check_all_zero("rsthold");
        rst = 1'b1;
        tick();
        do_start(4'b0001, basic_a, basic_v);
        e.cyc = 17; e.pass = 1'b1; e.cnt = 32'd16; sb.push_back(e);
        write(10, 5'd16, 32'h0000_1234);
        check("r2_mvec11", {28'd0, match_vec}, 32'hF);
        wait_done("rerun", 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mips_result_checker.md
# mips_result_checker

Synthesizable, parametrised pass/fail checker for the single-cycle MIPS core. It snoops the GPR write-back port and keeps shadow copies of up to NUM_CHK watched registers. It declares pass once every enabled watched register has held its expected value for SETTLE+1 consecutive cycles, and declares timeout if that does not happen within TIMEOUT run cycles. It sits beside the GPR file in the top level, so both simulation and FPGA builds get a self-checking result instead of polling a single register.

## Interface
Parameters:
- NUM_CHK, 4: number of watched-register channels (1..8).
- DW, 32: data width.
- RAW, 5: register address width.
- SETTLE, 5: extra consecutive all-match cycles required after the first one (≥1).
- TIMEOUT, 4096: maximum run cycles before timeout (≥2).

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; samples the configuration and begins a check.
- chk_en  in  NUM_CHK  per-channel enable; sampled at start.
- chk_addr  in  NUM_CHK*RAW  watched register number per channel; channel i occupies bits [i*RAW +: RAW]; sampled at start.
- chk_val  in  NUM_CHK*DW  expected value per channel; sampled at start.
- wb_en  in  1  GPR write enable.
- wb_addr  in  RAW  GPR write address.
- wb_data  in  DW  GPR write data.
- busy  out  1  high in RUN or SETTLE.
- done  out  1  high in PASS or TOUT.
- pass  out  1  high in PASS only.
- match_vec  out  NUM_CHK  per-channel match status, registered.
- cycle_cnt  out  32  number of run cycles elapsed; holds its value once done.

## Operation
- States: IDLE, RUN, SETTLE, PASS, TOUT. Reset puts the block in IDLE with every output 0.
- start is accepted in IDLE, PASS or TOUT; it is ignored while busy. On acceptance:
  - latch chk_en, chk_addr and chk_val;
  - clear every shadow_valid and match_vec bit;
  - clear cycle_cnt and the settle counter;
  - go to RUN.
- Channel i match condition: shadow_valid[i] && shadow[i]==val[i].
  - When addr[i]==0, the channel instead matches iff val[i]==0, independent of writes, because $0 is never written.
  - A disabled channel always reads as matched in match_vec.
- Snoop: when wb_en is high in RUN/SETTLE and wb_addr==addr[i]!=0, the next edge loads shadow[i]=wb_data and sets shadow_valid[i]=1. Several channels may watch the same address; all of them update.
- all_match is the AND of match_vec.
- RUN: if all_match, go to SETTLE with scnt=1.
- SETTLE: if !all_match, go to RUN with scnt=0. Else, if scnt==SETTLE, go to PASS. Otherwise scnt++.
- cycle_cnt increments on every RUN/SETTLE edge. When cycle_cnt==TIMEOUT-1 and the block is not entering PASS on that edge, go to TOUT. PASS wins over TOUT on the same edge.
- PASS and TOUT hold until the next start or reset. Snooping stops in these states; match_vec freezes.
- If no channel is enabled, the block passes after SETTLE+1 cycles.

## Timing
- start sampled at edge 0: busy is 1 from cycle 1.
- Write-back in cycle k: match_vec is updated in cycle k+1.
- If all_match is first high in cycle t and stays high, pass/done rise in cycle t+SETTLE+1. busy falls in the same cycle.
- Timeout: done=1, pass=0 in the cycle after cycle_cnt reached TIMEOUT-1. cycle_cnt then reads TIMEOUT.
- A write and start in the same cycle: start wins and the write is discarded.
- rst asserted at any time, including mid-run, forces IDLE and all outputs to 0 immediately. Latched configuration is cleared.

## Structure
- Package mips_chk_pkg holds:
  - the state enum (IDLE/RUN/SETTLE/PASS/TOUT);
  - the ZERO_REG constant (0);
  - default DW and RAW.
- Sub-module mips_chk_channel: one per channel via generate. It holds the latched addr/val/en, shadow and shadow_valid, snoop logic and match output, and takes a clear input driven by start.
- The top level holds the FSM, settle counter, cycle counter and output decode.

## Test plan
All scenarios use NUM_CHK=4, SETTLE=5, TIMEOUT=64.
- Basic pass:
  - Stimulus: enable ch0 only, addr 16, val 0x0000_1234; start, then write r16=0x1234 in cycle 10.
  - Response: match_vec[0]=1 in cycle 11; pass=done=1 in cycle 17; cycle_cnt=16.
- Disturbance:
  - Stimulus: as above, then write r16=0x0 in cycle 13 and r16=0x1234 in cycle 15.
  - Response: the block returns to RUN in cycle 15; pass rises in cycle 22.
- Timeout:
  - Stimulus: enable ch0, never write r16.
  - Response: done=1, pass=0 in cycle 65; cycle_cnt=64; busy=0.
- Mixed channels:
  - Stimulus: ch0 addr 0 val 0; ch1 addr 8 val 0xFFFF_FFFF; ch2 disabled; ch3 addr 8 val 0xFFFF_FFFF; write r8=0xFFFF_FFFF in cycle 3.
  - Response: match_vec=4'b1111 in cycle 4; pass in cycle 10.
- Restart and reset:
  - Stimulus: start pulses while busy; then rst low in cycle 8; after release, start again with the basic-pass stimulus.
  - Response: start while busy has no effect. While rst is low, all outputs are 0. After release, the basic-pass timing repeats exactly.
